ahb_read_master: RTL and testbench
==================================

Name: ahb_read_master

Overview:
- AHB-Lite read master. It is the read-side counterpart of the team's AHB write master.
- Given a base address, byte length and transfer size, it issues a pipelined INCR burst of reads, or repeated reads of a fixed address.
- Returned data goes into an internal FIFO that user logic drains through a simple pop interface.
- It sits between user datapath logic and the AHB interconnect, beside the write master, and uses the same control_* handshake.

Parameters:
- ADDRESSWIDTH, 32, width of HADDR and of the base/length inputs.
- DATAWIDTH, 32, width of HRDATA and of user data.
- FIFODEPTH, 32, read-data FIFO depth in words.
- FIFODEPTH_LOG, 5, log2(FIFODEPTH).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- control_fixed_location  in  1  1 = do not increment the address between beats.
- control_read_base  in  ADDRESSWIDTH  start byte address.
- control_read_length  in  ADDRESSWIDTH  total bytes; a multiple of the step size.
- control_go  in  1  one-cycle start pulse.
- control_done  out  1  all beats issued and all data captured.
- abort  out  1  error response received; held until the next go.
- data_size  in  3  000 byte, 001 halfword, 010 word; any other value is treated as word.
- user_read_buffer  in  1  pop one FIFO word.
- user_buffer_data  out  DATAWIDTH  FIFO head word (show-ahead).
- user_data_available  out  1  FIFO not empty.
- HSEL  out  1  constant 1.
- HREADY  in  1  transfer-complete / slave-ready.
- HRESP  in  2  bit0 = ERROR.
- HRDATA  in  DATAWIDTH  read data.
- HADDR  out  ADDRESSWIDTH  address-phase address.
- HWRITE  out  1  constant 0.
- HSIZE  out  3  registered data_size.
- HBURST  out  3  constant 001 (INCR).
- HPROT  out  4  constant 0011.
- HTRANS  out  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HREADYIN  out  1  constant 1.

Behaviour:
- Reset values:
  - state IDLE; address 0; length 0; dphase 0.
  - HSIZE 010; HTRANS 00.
  - FIFO empty, so user_data_available 0.
  - abort 0; control_done 1, because length and dphase are 0.
- control_go is accepted only in IDLE or ERR; it is ignored in all other states. On acceptance:
  - Latch base into address, length into length.
  - Latch data_size into HSIZE and the step (1, 2 or 4) into step_r.
  - Latch fixed_location.
  - Clear abort.
  - If the length is 0, stay in IDLE and do no bus activity.
- Credit check: credit = (fifo_count + dphase + 1) <= FIFODEPTH.
- States:
  - IDLE: HTRANS 00. On an accepted go with a nonzero length, go to NONSEQ.
  - NONSEQ: HTRANS = credit ? 10 : 00. Address accepted when HTRANS == 10 and HREADY. On acceptance:
    - if length == step_r, go to LAST;
    - else if fixed, stay in NONSEQ;
    - else go to SEQ.
  - SEQ: HTRANS = credit ? 11 : 01 (BUSY). Accepted when HTRANS == 11 and HREADY. Go to LAST when the accepted beat has length == step_r.
  - LAST: HTRANS 00. Wait for the final data phase to complete with HREADY, then go to IDLE.
  - ERR: HTRANS 00, abort = 1. Leave only on an accepted go.
- On each accepted address phase:
  - length -= step_r;
  - address += step_r unless fixed;
  - dphase <= 1 and lane_r <= HADDR[1:0];
  - otherwise, when a data phase completes with HREADY, dphase <= 0.
- Data phase:
  - When dphase & HREADY & !HRESP[0], push the extracted data.
  - Byte size: HRDATA >> (8*lane_r), zero-extended from 8 bits.
  - Halfword size: HRDATA >> (8*lane_r), zero-extended from 16 bits.
  - Word size: HRDATA unchanged.
- Error:
  - When dphase and HRESP[0]: no push; go to ERR on the first error cycle; HTRANS 00 from the next cycle.
  - length is frozen, so control_done stays 0.
- control_done = (state == IDLE) & (length == 0) & !dphase.
- FIFO: synchronous, show-ahead.
  - Push and pop in the same cycle is allowed and leaves the count unchanged.
  - A pop when empty is ignored.
  - The credit check guarantees a push never occurs when the FIFO is full.
- A reset mid-burst returns every register to its reset value on the next edge, and the FIFO is flushed.

Test Plan:
- Word burst: go, base 0x100, length 16, size 010, slave zero-wait → HTRANS 10,11,11,11 at HADDR 0x100..0x10C. The 4 words arrive in order. control_done rises one cycle after the last data phase.
- Fixed location, bytes: base 0x203, length 3, size 000, HRDATA 0xAABBCCDD → HTRANS 10,10,10 at 0x203 each beat. The FIFO receives 0x000000AA three times.
- Wait states: HREADY low 2 cycles on beat 2 → HADDR/HTRANS held stable, no duplicate push, 4 words total.
- FIFO backpressure: FIFODEPTH 4, length 32, no pops → exactly 4 beats issued, then HTRANS 01. After 2 pops, 2 more beats issue.
- Error: HRESP[0] = 1 on the 3rd data phase of an 8-word read → 2 words in the FIFO, abort = 1, HTRANS 00, control_done 0. A new go clears abort and restarts.
- Reset mid-burst: assert reset during SEQ → next cycle HTRANS 00, user_data_available 0, control_done 1.

Source files
------------

// File: rtl/ahb_read_master.sv
// ahb_read_master: AHB-Lite read master issuing INCR or fixed-address read bursts
// into a show-ahead FIFO drained by user logic.
module ahb_read_master #(
    parameter int ADDRESSWIDTH  = 32,
    parameter int DATAWIDTH     = 32,
    parameter int FIFODEPTH     = 32,
    parameter int FIFODEPTH_LOG = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0] control_read_base,
    input  logic [ADDRESSWIDTH-1:0] control_read_length,
    input  logic                    control_go,
    output logic                    control_done,
    output logic                    abort,
    input  logic [2:0]              data_size,
    input  logic                    user_read_buffer,
    output logic [DATAWIDTH-1:0]    user_buffer_data,
    output logic                    user_data_available,
    output logic                    HSEL,
    input  logic                    HREADY,
    input  logic [1:0]              HRESP,
    input  logic [DATAWIDTH-1:0]    HRDATA,
    output logic [ADDRESSWIDTH-1:0] HADDR,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [3:0]              HPROT,
    output logic [1:0]              HTRANS,
    output logic                    HREADYIN
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_NONSEQ = 3'd1;
    localparam logic [2:0] S_SEQ    = 3'd2;
    localparam logic [2:0] S_LAST   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;
    localparam logic [FIFODEPTH_LOG+1:0] C_DEPTH = (FIFODEPTH_LOG+2)'(FIFODEPTH);
    localparam logic [FIFODEPTH_LOG+1:0] C_ONE   = (FIFODEPTH_LOG+2)'(1);
    logic [2:0]               r_state;
    logic [ADDRESSWIDTH-1:0]  r_addr;
    logic [ADDRESSWIDTH-1:0]  r_len;
    logic                     r_dphase;
    logic [1:0]               r_lane;
    logic [2:0]               r_size;
    logic [2:0]               r_step;
    logic                     r_fixed;
    logic                     r_abort;
    logic [DATAWIDTH-1:0]     r_mem [FIFODEPTH];
    logic [FIFODEPTH_LOG-1:0] r_wptr;
    logic [FIFODEPTH_LOG-1:0] r_rptr;
    logic [FIFODEPTH_LOG:0]   r_count;
    logic [FIFODEPTH_LOG+1:0] w_need;
    logic                     w_credit;
    logic                     w_go;
    logic                     w_err;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_last;
    logic [2:0]               w_size;
    logic [2:0]               w_step;
    logic [ADDRESSWIDTH-1:0]  w_step_ext;
    logic [DATAWIDTH-1:0]     w_shift;
    logic [DATAWIDTH-1:0]     w_rdata;
    logic                     w_unused;
    assign HSEL     = 1'b1;
    assign HWRITE   = 1'b0;
    assign HBURST   = 3'b001;
    assign HPROT    = 4'b0011;
    assign HREADYIN = 1'b1;
    assign HADDR    = r_addr;
    assign HSIZE    = r_size;
    assign abort    = r_abort;
    assign w_unused = HRESP[1];
    // Room must exist for every word already in flight plus the one being requested.
    assign w_need     = {1'b0, r_count} + {{(FIFODEPTH_LOG+1){1'b0}}, r_dphase} + C_ONE;
    assign w_credit   = w_need <= C_DEPTH;
    assign w_go       = control_go & (r_state == S_IDLE | r_state == S_ERR);
    assign w_err      = r_dphase & HRESP[0];
    assign w_accept   = HTRANS[1] & HREADY & ~w_err;
    assign w_push     = r_dphase & HREADY & ~HRESP[0];
    assign w_pop      = user_read_buffer & (r_count != '0);
    assign w_step_ext = ADDRESSWIDTH'(r_step);
    assign w_last     = r_len == w_step_ext;
    assign w_size     = data_size == 3'b000 ? 3'b000 : data_size == 3'b001 ? 3'b001 : 3'b010;
    assign w_step     = w_size == 3'b000 ? 3'd1 : w_size == 3'b001 ? 3'd2 : 3'd4;
    assign w_shift    = HRDATA >> {r_lane, 3'b000};
    assign w_rdata    = r_size == 3'b000 ? DATAWIDTH'(w_shift[7:0]) :
                        r_size == 3'b001 ? DATAWIDTH'(w_shift[15:0]) : HRDATA;
    assign control_done        = (r_state == S_IDLE) & (r_len == '0) & ~r_dphase;
    assign user_buffer_data    = r_mem[r_rptr];
    assign user_data_available = r_count != '0;
    always_comb begin
        HTRANS = r_state == S_NONSEQ ? (w_credit ? 2'b10 : 2'b00) :
                 r_state == S_SEQ    ? (w_credit ? 2'b11 : 2'b01) : 2'b00;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_dphase <= 1'b0;
            r_lane   <= 2'b00;
            r_size   <= 3'b010;
            r_step   <= 3'd4;
            r_fixed  <= 1'b0;
            r_abort  <= 1'b0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
        end else begin
            if (w_go) begin
                r_addr  <= control_read_base;
                r_len   <= control_read_length;
                r_size  <= w_size;
                r_step  <= w_step;
                r_fixed <= control_fixed_location;
                r_abort <= 1'b0;
                r_state <= control_read_length == '0 ? S_IDLE : S_NONSEQ;
            end else if (w_err) begin
                r_state <= S_ERR;
                r_abort <= 1'b1;
            end else if (w_accept) begin
                r_len   <= r_len - w_step_ext;
                r_addr  <= r_fixed ? r_addr : r_addr + w_step_ext;
                r_state <= w_last ? S_LAST : r_fixed ? S_NONSEQ : S_SEQ;
            end else if (r_state == S_LAST & r_dphase & HREADY) begin
                r_state <= S_IDLE;
            end
            if (w_accept) begin
                r_dphase <= 1'b1;
                r_lane   <= r_addr[1:0];
            end else if (HREADY) begin
                r_dphase <= 1'b0;
            end
            r_wptr  <= w_push ? r_wptr + FIFODEPTH_LOG'(1) : r_wptr;
            r_rptr  <= w_pop ? r_rptr + FIFODEPTH_LOG'(1) : r_rptr;
            r_count <= (w_push & ~w_pop) ? r_count + (FIFODEPTH_LOG+1)'(1) :
                       (~w_push & w_pop) ? r_count - (FIFODEPTH_LOG+1)'(1) : r_count;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_rdata;
    end
endmodule

// File: tb/tb_ahb_read_master.sv
// tb_ahb_read_master: cycle-level AHB slave model with a scoreboard of expected FIFO words.
module tb_ahb_read_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        control_fixed_location = 1'b0;
    logic [31:0] control_read_base = '0;
    logic [31:0] control_read_length = '0;
    logic        control_go = 1'b0;
    logic        control_done;
    logic        abort;
    logic [2:0]  data_size = 3'b010;
    logic        user_read_buffer = 1'b0;
    logic [31:0] user_buffer_data;
    logic        user_data_available;
    logic        HSEL;
    logic        HREADY = 1'b1;
    logic [1:0]  HRESP = 2'b00;
    logic [31:0] HRDATA = '0;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HREADYIN;

    always #5 clk = ~clk;

    ahb_read_master #(.ADDRESSWIDTH(32), .DATAWIDTH(32), .FIFODEPTH(4), .FIFODEPTH_LOG(2)) dut (
        .clk(clk), .reset(reset), .control_fixed_location(control_fixed_location),
        .control_read_base(control_read_base), .control_read_length(control_read_length),
        .control_go(control_go), .control_done(control_done), .abort(abort),
        .data_size(data_size), .user_read_buffer(user_read_buffer),
        .user_buffer_data(user_buffer_data), .user_data_available(user_data_available),
        .HSEL(HSEL), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HREADYIN(HREADYIN)
    );

    typedef struct {
        logic [31:0] base;
        logic [31:0] len;
        logic [2:0]  size;
        bit          fixed;
        bit          use_c;
        logic [31:0] cval;
        int          exp_beats;
        logic [31:0] exp_last;
    } vec_t;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    bit          pop_en, use_const, tb_dp, exp_fixed, chk_done, prev_hold;
    logic [31:0] cval, tb_dp_addr, tb_dp_exp_addr, exp_addr, last_addr, prev_addr;
    logic [2:0]  exp_size;
    logic [1:0]  prev_trans;
    int          exp_step, dp_idx, beats, total, err_stage;
    int          ws_beat = -1;
    int          ws_left = 0;
    int          err_beat = -1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] extract(logic [31:0] d, logic [31:0] a, logic [2:0] s);
        logic [31:0] sh;
        sh = d >> (8 * a[1:0]);
        return s == 3'b000 ? {24'h0, sh[7:0]} : s == 3'b001 ? {16'h0, sh[15:0]} : d;
    endfunction

    // One bus clock: called at a negedge, drives the slave side, models the edge, returns at the next negedge.
    task automatic step_cycle();
        if (prev_hold) begin
            check("hold_htrans", 32'(HTRANS), 32'(prev_trans));
            check("hold_haddr", HADDR, prev_addr);
        end
        check("avail", 32'(user_data_available), 32'(sb_q.size() != 0));
        if (chk_done) check("done", 32'(control_done), 32'(beats == total && !tb_dp && err_stage == 0));
        user_read_buffer = pop_en;
        HRESP = 2'b00;
        HREADY = 1'b1;
        if (tb_dp && err_stage == 1) begin
            HRESP = 2'b01;
            err_stage = 2;
        end else if (tb_dp && dp_idx == err_beat && err_stage == 0) begin
            HREADY = 1'b0;
            HRESP = 2'b01;
            err_stage = 1;
        end else if (tb_dp && dp_idx == ws_beat && ws_left > 0) begin
            HREADY = 1'b0;
            ws_left--;
        end
        HRDATA = use_const ? cval : mem(tb_dp_addr);
        prev_hold = HTRANS[1] && !HREADY && !HRESP[0];
        prev_trans = HTRANS;
        prev_addr = HADDR;
        if (pop_en && sb_q.size() > 0) check("pop_data", user_buffer_data, sb_q.pop_front());
        if (tb_dp && HREADY) begin
            if (!HRESP[0]) sb_q.push_back(extract(HRDATA, tb_dp_exp_addr, exp_size));
            tb_dp = 1'b0;
            dp_idx++;
        end
        if (HTRANS[1] && HREADY) begin
            check("haddr", HADDR, exp_addr);
            check("htrans", 32'(HTRANS), (beats == 0 || exp_fixed) ? 32'h2 : 32'h3);
            check("hsize", 32'(HSIZE), 32'(exp_size));
            tb_dp = 1'b1;
            tb_dp_addr = HADDR;
            tb_dp_exp_addr = exp_addr;
            last_addr = HADDR;
            beats++;
            if (!exp_fixed) exp_addr += exp_step;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_go(logic [31:0] base, logic [31:0] len, logic [2:0] size, bit fixed);
        exp_addr = base;
        exp_size = size;
        exp_step = size == 3'b000 ? 1 : size == 3'b001 ? 2 : 4;
        exp_fixed = fixed;
        total = int'(len) / exp_step;
        beats = 0;
        dp_idx = 0;
        err_stage = 0;
        last_addr = '0;
        control_read_base = base;
        control_read_length = len;
        data_size = size;
        control_fixed_location = fixed;
        control_go = 1'b1;
        chk_done = 1'b0;
        step_cycle();
        control_go = 1'b0;
        chk_done = 1'b1;
        check("abort_after_go", 32'(abort), 32'h0);
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while (!(beats == total && !tb_dp) && n < budget) begin
            step_cycle();
            n++;
        end
        check("burst_timeout", 32'(n < budget), 32'h1);
    endtask

    task automatic drain();
        int n = 0;
        pop_en = 1'b1;
        while ((sb_q.size() != 0 || tb_dp) && n < 100) begin
            step_cycle();
            n++;
        end
        repeat (2) step_cycle();
    endtask

    task automatic run_xfer(logic [31:0] base, logic [31:0] len, logic [2:0] size, bit fixed,
                            int eb, logic [31:0] el);
        pop_en = 1'b1;
        start_go(base, len, size, fixed);
        wait_done(300);
        drain();
        check("beats", 32'(beats), 32'(eb));
        check("last_addr", last_addr, el);
        check("done_end", 32'(control_done), 32'h1);
        check("avail_end", 32'(user_data_available), 32'h0);
    endtask

    initial begin
        vec_t vecs[7];
        int   n;
        vecs[0] = '{32'h100, 32'd16, 3'b010, 1'b0, 1'b0, 32'h0, 4, 32'h10C};
        vecs[1] = '{32'h203, 32'd3, 3'b000, 1'b1, 1'b1, 32'hAABBCCDD, 3, 32'h203};
        vecs[2] = '{32'h402, 32'd8, 3'b001, 1'b0, 1'b0, 32'h0, 4, 32'h408};
        vecs[3] = '{32'h011, 32'd5, 3'b000, 1'b0, 1'b1, 32'h11223344, 5, 32'h015};
        vecs[4] = '{32'h700, 32'd0, 3'b010, 1'b0, 1'b0, 32'h0, 0, 32'h0};
        vecs[5] = '{32'h080, 32'd12, 3'b010, 1'b1, 1'b0, 32'h0, 3, 32'h080};
        vecs[6] = '{32'h0FC, 32'd4, 3'b010, 1'b0, 1'b0, 32'h0, 1, 32'h0FC};
        pop_en = 1'b0;
        use_const = 1'b0;
        tb_dp = 1'b0;
        chk_done = 1'b0;
        prev_hold = 1'b0;
        total = 0;
        beats = 0;
        err_stage = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_hsize", 32'(HSIZE), 32'h2);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_avail", 32'(user_data_available), 32'h0);
        check("rst_abort", 32'(abort), 32'h0);
        check("rst_done", 32'(control_done), 32'h1);
        check("const_bus", {20'h0, HSEL, HWRITE, HBURST, HPROT, HREADYIN, 2'b00},
              {20'h0, 1'b1, 1'b0, 3'b001, 4'b0011, 1'b1, 2'b00});

        for (int i = 0; i < 7; i++) begin
            use_const = vecs[i].use_c;
            cval = vecs[i].cval;
            run_xfer(vecs[i].base, vecs[i].len, vecs[i].size, vecs[i].fixed,
                     vecs[i].exp_beats, vecs[i].exp_last);
        end
        use_const = 1'b0;

        ws_beat = 1;
        ws_left = 2;
        run_xfer(32'h100, 32'd16, 3'b010, 1'b0, 4, 32'h10C);
        ws_beat = -1;

        pop_en = 1'b0;
        start_go(32'h600, 32'd32, 3'b010, 1'b0);
        repeat (12) step_cycle();
        check("bp_beats4", 32'(beats), 32'd4);
        check("bp_busy", 32'(HTRANS), 32'h1);
        pop_en = 1'b1;
        repeat (2) step_cycle();
        pop_en = 1'b0;
        repeat (10) step_cycle();
        check("bp_beats6", 32'(beats), 32'd6);
        check("bp_busy2", 32'(HTRANS), 32'h1);

        pop_en = 1'b1;
        repeat (3) step_cycle();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_htrans", 32'(HTRANS), 32'h0);
        check("mid_rst_avail", 32'(user_data_available), 32'h0);
        check("mid_rst_done", 32'(control_done), 32'h1);
        sb_q.delete();
        tb_dp = 1'b0;
        prev_hold = 1'b0;
        chk_done = 1'b0;
        run_xfer(32'h040, 32'd8, 3'b010, 1'b0, 2, 32'h044);

        pop_en = 1'b0;
        err_beat = 2;
        start_go(32'h300, 32'd32, 3'b010, 1'b0);
        n = 0;
        while (err_stage != 2 && n < 50) begin
            step_cycle();
            n++;
        end
        check("err_timeout", 32'(n < 50), 32'h1);
        err_beat = -1;
        check("err_abort", 32'(abort), 32'h1);
        check("err_htrans", 32'(HTRANS), 32'h0);
        check("err_done", 32'(control_done), 32'h0);
        repeat (2) step_cycle();
        check("err_words", 32'(sb_q.size()), 32'd2);
        check("err_abort_hold", 32'(abort), 32'h1);
        run_xfer(32'h500, 32'd16, 3'b010, 1'b0, 4, 32'h50C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
